mips_rf_write_arbiter: RTL and testbench
========================================

Name: mips_rf_write_arbiter

Overview:
- Owns the single write port of the MIPS register file and shares it among NREQ writeback requesters, for example the ALU, the load unit and the mul/div unit.
- Each requester uses a valid/ready handshake.
- Arbitration is round-robin.
- After reset, the block sequences a clear of all 32 registers before accepting any requests.
- Sits between the writeback stage sources and the register file's wen/WA/WD inputs.

Parameters:
- NREQ, default 3: number of requesters; legal range 2..8.
- AWL, default 5: register address width.
- DWL, default 32: data width.
- CLEAR_ON_RESET, default 1: 1 = run the 32-entry zero-fill sequence after reset; 0 = skip it.

Ports:
- clk, input, 1: system clock; all state is updated on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- hold, input, 1: when 1, no new grants are issued in RUN; a transfer already accepted still completes.
- req_valid, input, NREQ: per-requester write request.
- req_addr, input, NREQ*AWL: packed destination addresses; requester i occupies bits [i*AWL +: AWL].
- req_data, input, NREQ*DWL: packed write data; requester i occupies bits [i*DWL +: DWL].
- req_ready, output, NREQ: one-hot-or-zero grant, combinational.
- rf_wen, output, 1: register file write enable, registered.
- rf_wa, output, AWL: register file write address, registered.
- rf_wd, output, DWL: register file write data, registered.
- grant_id, output, clog2(NREQ): index of the last accepted requester, registered.
- init_done, output, 1: high once in the RUN state.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rf_wen=0, rf_wa=0, rf_wd=0, grant_id=0, init_done=0.
  - Round-robin pointer = 0; clear counter = 0; state = INIT.
  - req_ready=0 while in reset.
- States: INIT and RUN.
- INIT, with CLEAR_ON_RESET=1:
  - Each cycle registers rf_wen=1, rf_wa=counter, rf_wd=0; counter increments.
  - When counter=31 is issued, the next state is RUN.
  - rf_wen is seen high at addresses 0..31 on 32 consecutive cycles.
  - req_ready=0 throughout INIT.
- INIT, with CLEAR_ON_RESET=0: moves to RUN on the first clock after reset release, with no writes.
- init_done: registered; it is 1 in the cycle after the last clear write is registered (or the first RUN cycle) and stays 1 until the next reset.
- RUN grant selection:
  - The granted requester g is the first i with req_valid[i]=1, searching from the pointer upward, modulo NREQ.
  - req_ready[g]=1 only when hold=0.
  - req_ready may depend combinationally on req_valid.
  - At most one req_ready bit is ever high.
- Transfer: a transfer occurs when req_valid[g] and req_ready[g] are both 1. At the next edge:
  - rf_wen=1, rf_wa=req_addr[g], rf_wd=req_data[g], grant_id=g.
  - Pointer = (g+1) mod NREQ.
  - Latency from accept to write-port visibility is exactly 1 cycle.
  - Sustained throughput is one write per cycle.
- No transfer in a cycle (no valid requester, or hold=1): next rf_wen=0; rf_wa, rf_wd and grant_id hold their values; the pointer is unchanged.
- Requester obligations: a requester holds valid, addr and data stable until it is granted ready. The arbiter never drops an accepted request.
- Fairness: with all NREQ requesters continuously valid, each is granted exactly once per NREQ cycles.
- Simultaneous events:
  - hold=1 and valid in the same cycle: no grant; the pointer is not advanced.
  - An address collision between requesters is not checked; writes are serialized in grant order.
- Reset mid-operation: an asserted rst_n=0 during INIT or RUN immediately clears all state. Any pending registered write is lost (rf_wen=0). INIT restarts from address 0.

Optional Feature:
- Macro: MIPS_RF_ARB_R0_FILTER_EN.
- Defined:
  - A request with req_addr=0 is still accepted (ready/handshake, pointer advance and grant_id update as normal).
  - rf_wen is forced to 0 for that transfer; rf_wa and rf_wd are still registered.
  - The INIT clear of address 0 is still issued.
- Undefined: writes to address 0 pass through like any other address.

Test Plan:
- Reset with CLEAR_ON_RESET=1 -> 32 cycles of rf_wen=1 with rf_wa=0..31 and rf_wd=0; init_done=1 after the last one; req_ready=0 throughout, even with req_valid=3'b111.
- RUN, requester 1 only, addr=5, data=32'hDEADBEEF -> req_ready=3'b010 that cycle; next cycle rf_wen=1, rf_wa=5, rf_wd=32'hDEADBEEF, grant_id=1.
- RUN, req_valid=3'b111 held with distinct data per requester, pointer=0 -> grant order 0,1,2,0,1,2; one rf_wen pulse per cycle.
- hold=1 for 3 cycles with req_valid=3'b100 -> req_ready=0 and rf_wen=0 for 3 cycles; the first cycle after hold drops grants requester 2.
- rst_n pulsed low at INIT counter=10 -> outputs return to 0 immediately; the clear restarts at rf_wa=0 and runs the full 32 writes.
- With MIPS_RF_ARB_R0_FILTER_EN, requester 0 addr=0, data=7 -> ready=1, grant_id=0, rf_wen=0; without the macro -> rf_wen=1, rf_wa=0, rf_wd=7.

Source files
------------

// File: rtl/mips_rf_write_arbiter.sv
// mips_rf_write_arbiter
// Shares the single MIPS register-file write port among NREQ writeback
// requesters using round-robin arbitration. After reset an INIT phase can
// zero-fill all 32 registers (CLEAR_ON_RESET=1) before any request is granted.
//
// Handshake: requester i presents req_valid[i] with stable req_addr/req_data;
// a transfer happens in a cycle where req_valid[i] && req_ready[i]. req_ready
// is combinational, one-hot-or-zero, and never asserted in INIT or under hold.
// The accepted write appears on rf_wen/rf_wa/rf_wd exactly one cycle later.
//
// Optional build macro: MIPS_RF_ARB_R0_FILTER_EN -- requests to register 0
// are accepted normally but do not assert rf_wen (INIT clear of r0 still runs).
module mips_rf_write_arbiter #(
  parameter int NREQ           = 3,
  parameter int AWL            = 5,
  parameter int DWL            = 32,
  parameter int CLEAR_ON_RESET = 1,
  localparam int GW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*AWL-1:0] req_addr,
  input  logic [NREQ*DWL-1:0] req_data,
  output logic [NREQ-1:0]     req_ready,
  output logic                rf_wen,
  output logic [AWL-1:0]      rf_wa,
  output logic [DWL-1:0]      rf_wd,
  output logic [GW-1:0]       grant_id,
  output logic                init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [4:0]     clr_cnt_q, clr_cnt_d;
  logic [GW-1:0]  ptr_q, ptr_d;

  logic           wen_d;
  logic [AWL-1:0] wa_d;
  logic [DWL-1:0] wd_d;
  logic [GW-1:0]  gid_d;

  logic           found;
  logic [GW-1:0]  gnt_idx;
  logic [GW:0]    scan_idx;
  logic           xfer;
  logic [AWL-1:0] sel_addr;
  logic [DWL-1:0] sel_data;
  logic           sel_wen;

  // Round-robin search: first valid requester starting at the pointer.
  always_comb begin
    found    = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (GW+1)'(k);
      if (scan_idx >= (GW+1)'(NREQ)) begin
        scan_idx = scan_idx - (GW+1)'(NREQ);
      end
      if (!found && req_valid[scan_idx[GW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = scan_idx[GW-1:0];
      end
    end
  end

  // Grant is only offered in RUN and while hold is low.
  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    if (state_q == ST_RUN && !hold && found) begin
      req_ready[gnt_idx] = 1'b1;
      xfer               = 1'b1;
    end
  end

  // Select the granted requester's payload and decide whether it writes.
  always_comb begin
    sel_addr = req_addr[gnt_idx*AWL +: AWL];
    sel_data = req_data[gnt_idx*DWL +: DWL];
`ifdef MIPS_RF_ARB_R0_FILTER_EN
    sel_wen  = (sel_addr != '0);
`else
    sel_wen  = 1'b1;
`endif
  end

  // Next-state and next-output logic for the INIT/RUN controller.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ptr_d     = ptr_q;
    wen_d     = 1'b0;
    wa_d      = rf_wa;
    wd_d      = rf_wd;
    gid_d     = grant_id;
    case (state_q)
      ST_INIT: begin
        if (CLEAR_ON_RESET != 0) begin
          wen_d     = 1'b1;
          wa_d      = AWL'(clr_cnt_q);
          wd_d      = '0;
          clr_cnt_d = clr_cnt_q + 5'd1;
          if (clr_cnt_q == 5'd31) begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          wen_d = sel_wen;
          wa_d  = sel_addr;
          wd_d  = sel_data;
          gid_d = gnt_idx;
          ptr_d = (gnt_idx == GW'(NREQ-1)) ? '0 : gnt_idx + GW'(1);
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
      ptr_q     <= '0;
      init_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ptr_q     <= ptr_d;
      init_done <= (state_d == ST_RUN);
    end
  end

  // Registered write port toward the register file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_wa    <= '0;
      rf_wd    <= '0;
      grant_id <= '0;
    end else begin
      rf_wen   <= wen_d;
      rf_wa    <= wa_d;
      rf_wd    <= wd_d;
      grant_id <= gid_d;
    end
  end

endmodule

// File: tb/tb_mips_rf_write_arbiter.sv
// tb_mips_rf_write_arbiter
// Directed bench for mips_rf_write_arbiter (NREQ=3, AWL=5, DWL=32,
// CLEAR_ON_RESET=1). Expected writes are queued as {wa, wd, grant_id} when
// stimulus is issued; a negedge monitor pops one entry per rf_wen pulse.
module tb_mips_rf_write_arbiter;

  localparam int NREQ = 3;
  localparam int AWL  = 5;
  localparam int DWL  = 32;
  localparam int GW   = 2;
  localparam int EW   = AWL + DWL + GW;

  logic                clk;
  logic                rst_n;
  logic                hold;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AWL-1:0] req_addr;
  logic [NREQ*DWL-1:0] req_data;
  logic [NREQ-1:0]     req_ready;
  logic                rf_wen;
  logic [AWL-1:0]      rf_wa;
  logic [DWL-1:0]      rf_wd;
  logic [GW-1:0]       grant_id;
  logic                init_done;

  logic [EW-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  mips_rf_write_arbiter #(
    .NREQ(NREQ), .AWL(AWL), .DWL(DWL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hold(hold),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready), .rf_wen(rf_wen), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .grant_id(grant_id), .init_done(init_done)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [AWL-1:0] wa, input logic [DWL-1:0] wd, input logic [GW-1:0] gid);
    exp_q.push_back({wa, wd, gid});
  endtask

  task automatic set_req(input logic [NREQ-1:0] v,
                         input logic [AWL-1:0] a0, input logic [AWL-1:0] a1, input logic [AWL-1:0] a2,
                         input logic [DWL-1:0] d0, input logic [DWL-1:0] d1, input logic [DWL-1:0] d2);
    req_valid = v;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  // Wait for the clear sequence to finish; ready must stay low meanwhile.
  task automatic run_init();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (init_done) begin
        done = 1'b1;
        break;
      end
      check("init_ready_low", 64'(req_ready), 64'(0));
    end
    check("init_done_reached", 64'(done), 64'(1));
    check("init_last_write", 64'({rf_wen, rf_wa}), 64'({1'b1, 5'd31}));
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n && rf_wen) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wb_unexpected actual=%0h/%0h/%0h required=no write", rf_wa, rf_wd, grant_id);
      end else begin
        check("wb_write", 64'({rf_wa, rf_wd, grant_id}), 64'(exp_q.pop_front()));
      end
    end
  end

  // Stimulus
  initial begin
    rst_n = 1'b0;
    hold  = 1'b0;
    set_req(3'b111, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    #3;
    check("reset_outputs", 64'({rf_wen, rf_wa, rf_wd, grant_id, init_done}), 64'(0));
    check("reset_ready", 64'(req_ready), 64'(0));

    // Clear sequence with all requesters valid
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) push_exp(AWL'(i), '0, '0);
    run_init();

    // Single requester 1
    @(posedge clk); #1;
    set_req(3'b010, 5'd0, 5'd5, 5'd0, 32'd0, 32'hDEADBEEF, 32'd0);
    #1;
    check("single_ready", 64'(req_ready), 64'(3'b010));
    push_exp(5'd5, 32'hDEADBEEF, 2'd1);
    @(posedge clk); #1;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check("single_latency", 64'({rf_wen, rf_wa, grant_id}), 64'({1'b1, 5'd5, 2'd1}));

    // Hold with requester 2 valid (pointer is 2 here)
    @(posedge clk); #1;
    hold = 1'b1;
    set_req(3'b100, 5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'h0000_0C0D);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      #1;
      check("hold_ready", 64'(req_ready), 64'(0));
      check("hold_wen", 64'(rf_wen), 64'(0));
    end
    @(posedge clk); #1;
    hold = 1'b0;
    #1;
    check("hold_wen_last", 64'(rf_wen), 64'(0));
    check("post_hold_ready", 64'(req_ready), 64'(3'b100));
    push_exp(5'd9, 32'h0000_0C0D, 2'd2);

    // All valid from pointer 0: grant order 0,1,2,0,1,2
    @(posedge clk); #1;
    set_req(3'b111, 5'd1, 5'd2, 5'd3, 32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      #1;
      case (i % 3)
        0: begin check("rr_ready", 64'(req_ready), 64'(3'b001)); push_exp(5'd1, 32'hA0A0_0000, 2'd0); end
        1: begin check("rr_ready", 64'(req_ready), 64'(3'b010)); push_exp(5'd2, 32'hA1A1_1111, 2'd1); end
        default: begin check("rr_ready", 64'(req_ready), 64'(3'b100)); push_exp(5'd3, 32'hA2A2_2222, 2'd2); end
      endcase
    end
    @(posedge clk); #1;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);

    // Write to register 0 from requester 0 (pointer is 0 again)
    @(posedge clk); #1;
    set_req(3'b001, 5'd0, 5'd0, 5'd0, 32'd7, 32'd0, 32'd0);
    #1;
    check("r0_ready", 64'(req_ready), 64'(3'b001));
`ifndef MIPS_RF_ARB_R0_FILTER_EN
    push_exp(5'd0, 32'd7, 2'd0);
`endif
    @(posedge clk); #1;
    set_req(3'b000, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    check("r0_grant_id", 64'(grant_id), 64'(0));
`ifdef MIPS_RF_ARB_R0_FILTER_EN
    check("r0_wen_filtered", 64'(rf_wen), 64'(0));
`else
    check("r0_wen", 64'(rf_wen), 64'(1));
`endif
    repeat (3) @(posedge clk);
    #1;
    check("run_drain", 64'(exp_q.size()), 64'(0));

    // Reset pulsed at clear counter 10: writes 0..8 are seen, 9 is lost
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) push_exp(AWL'(i), '0, '0);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_outputs", 64'({rf_wen, rf_wa, rf_wd, grant_id, init_done}), 64'(0));
    check("midreset_drain", 64'(exp_q.size()), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) push_exp(AWL'(i), '0, '0);
    run_init();
    repeat (2) @(posedge clk);
    #1;
    check("final_drain", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
